// File: rtl/bp_fe_btb_ctrl.sv
// Front-end BTB control: arbitrates fetch lookups and buffered backend updates onto the
// single-ported BTB, keeps per-entry partial tags and reports tagged predictions one cycle later.
module bp_fe_btb_ctrl #(
    parameter int eaddr_width_p   = 39,
    parameter int btb_idx_width_p = 9,
    parameter int btb_tag_width_p = 8,
    parameter int starve_limit_p  = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       flush_i,

    input  logic                       fetch_v_i,
    input  logic [eaddr_width_p-1:0]   fetch_pc_i,
    output logic                       fetch_ready_o,

    output logic                       pred_v_o,
    output logic [eaddr_width_p-1:0]   pred_pc_o,
    output logic                       pred_hit_o,
    output logic [eaddr_width_p-1:0]   pred_target_o,

    input  logic                       upd_v_i,
    input  logic [eaddr_width_p-1:0]   upd_pc_i,
    input  logic [eaddr_width_p-1:0]   upd_target_i,
    output logic                       upd_ready_o,

    output logic [btb_idx_width_p-1:0] btb_idx_r_o,
    output logic                       btb_r_v_o,
    output logic [btb_idx_width_p-1:0] btb_idx_w_o,
    output logic                       btb_w_v_o,
    output logic [eaddr_width_p-1:0]   btb_target_w_o,
    input  logic [eaddr_width_p-1:0]   btb_target_i,
    input  logic                       btb_read_valid_i
);

    localparam int tag_lo_lp   = btb_idx_width_p + 2;
    localparam int tag_hi_lp   = btb_tag_width_p + btb_idx_width_p + 1;
    localparam int starve_w_lp = (starve_limit_p > 1) ? $clog2(starve_limit_p) : 1;
    localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p - 1);

    typedef struct packed {
        logic [btb_idx_width_p-1:0] idx;
        logic [btb_tag_width_p-1:0] tag;
        logic [eaddr_width_p-1:0]   target;
    } upd_entry_s;

    upd_entry_s                 fifo_mem [2];
    upd_entry_s                 head;
    upd_entry_s                 upd_entry;
    logic                       head_r;
    logic                       tail;
    logic [1:0]                 count_r;
    logic [starve_w_lp-1:0]     starve_r;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       starve_hit;
    logic                       drain;
    logic                       enq;
    logic                       fetch_accept;

    logic [btb_tag_width_p-1:0] tag_arr [2**btb_idx_width_p];
    logic [btb_tag_width_p-1:0] tag_q;
    logic [eaddr_width_p-1:0]   pc_q;
    logic                       v_q;
    logic [btb_idx_width_p-1:0] fetch_idx;
    logic                       unused;

    assign fetch_idx  = fetch_pc_i[btb_idx_width_p+1:2];
    assign upd_entry  = '{idx:    upd_pc_i[btb_idx_width_p+1:2],
                          tag:    upd_pc_i[tag_hi_lp:tag_lo_lp],
                          target: upd_target_i};
    assign unused     = ^{upd_pc_i[1:0], upd_pc_i[eaddr_width_p-1:tag_hi_lp+1]};

    assign head       = fifo_mem[head_r];
    // With two slots the tail is the head offset by the occupancy parity; a full FIFO refills the head slot.
    assign tail       = head_r ^ count_r[0];
    assign fifo_full  = (count_r == 2'd2);
    assign fifo_empty = (count_r == 2'd0);
    assign starve_hit = (starve_r == starve_max_lp);

    // Reset is folded into every handshake so nothing leaks out while reset is held.
    assign drain         = reset_n_i & !fifo_empty & (fifo_full | starve_hit | !fetch_v_i | flush_i);
    assign fetch_ready_o = reset_n_i & !drain & !flush_i;
    assign fetch_accept  = fetch_v_i & fetch_ready_o;
    assign upd_ready_o   = reset_n_i & !fifo_full;
    assign enq           = upd_v_i & upd_ready_o;

    assign btb_idx_r_o    = fetch_idx;
    assign btb_r_v_o      = fetch_accept;
    assign btb_idx_w_o    = head.idx;
    assign btb_target_w_o = head.target;
    assign btb_w_v_o      = drain;

    assign pred_v_o      = reset_n_i & v_q & !flush_i;
    assign pred_pc_o     = pc_q;
    assign pred_hit_o    = btb_read_valid_i & (tag_q == pc_q[tag_hi_lp:tag_lo_lp]);
    assign pred_target_o = pred_hit_o ? btb_target_i : '0;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            head_r   <= 1'b0;
            count_r  <= 2'd0;
            starve_r <= '0;
            v_q      <= 1'b0;
        end else begin
            if (drain)
                head_r <= ~head_r;
            count_r <= count_r + 2'(enq) - 2'(drain);
            if (fifo_empty || drain)
                starve_r <= '0;
            else if (!starve_hit)
                starve_r <= starve_r + 1'b1;
            v_q <= fetch_accept;
        end
    end

    // Payload storage carries no reset; validity comes from the FIFO count and the BTB itself.
    always_ff @(posedge clk_i) begin
        if (enq)
            fifo_mem[tail] <= upd_entry;
        if (drain)
            tag_arr[head.idx] <= head.tag;
        if (fetch_accept) begin
            pc_q  <= fetch_pc_i;
            tag_q <= tag_arr[fetch_idx];
        end
    end

endmodule

// File: tb/tb_bp_fe_btb_ctrl.sv
// Self-checking bench for bp_fe_btb_ctrl: directed scenarios plus randomized traffic
// against a queue/array reference model, with a simple BTB memory attached.
module tb_bp_fe_btb_ctrl;

    localparam int EW = 39;
    localparam int IW = 9;
    localparam int TW = 8;
    localparam int SL = 8;
    localparam int N  = 1 << IW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          fetch_v = 1'b0;
    logic [EW-1:0] fetch_pc = '0;
    logic          fetch_ready;
    logic          pred_v;
    logic [EW-1:0] pred_pc;
    logic          pred_hit;
    logic [EW-1:0] pred_target;
    logic          upd_v = 1'b0;
    logic [EW-1:0] upd_pc = '0;
    logic [EW-1:0] upd_target = '0;
    logic          upd_ready;
    logic [IW-1:0] btb_idx_r;
    logic          btb_r_v;
    logic [IW-1:0] btb_idx_w;
    logic          btb_w_v;
    logic [EW-1:0] btb_target_w;
    logic [EW-1:0] btb_target = '0;
    logic          btb_read_valid = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    bp_fe_btb_ctrl #(
        .eaddr_width_p  (EW),
        .btb_idx_width_p(IW),
        .btb_tag_width_p(TW),
        .starve_limit_p (SL)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .flush_i         (flush),
        .fetch_v_i       (fetch_v),
        .fetch_pc_i      (fetch_pc),
        .fetch_ready_o   (fetch_ready),
        .pred_v_o        (pred_v),
        .pred_pc_o       (pred_pc),
        .pred_hit_o      (pred_hit),
        .pred_target_o   (pred_target),
        .upd_v_i         (upd_v),
        .upd_pc_i        (upd_pc),
        .upd_target_i    (upd_target),
        .upd_ready_o     (upd_ready),
        .btb_idx_r_o     (btb_idx_r),
        .btb_r_v_o       (btb_r_v),
        .btb_idx_w_o     (btb_idx_w),
        .btb_w_v_o       (btb_w_v),
        .btb_target_w_o  (btb_target_w),
        .btb_target_i    (btb_target),
        .btb_read_valid_i(btb_read_valid)
    );

    always #5 clk = ~clk;

    // BTB memory: synchronous read, valid bits cleared by (inverted) reset.
    bit            bv [N];
    logic [EW-1:0] bt [N];
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) bv[i] <= 1'b0;
            btb_read_valid <= 1'b0;
        end else begin
            if (btb_w_v) begin
                bv[btb_idx_w] <= 1'b1;
                bt[btb_idx_w] <= btb_target_w;
            end
            if (btb_r_v) begin
                btb_read_valid <= bv[btb_idx_r];
                btb_target     <= bt[btb_idx_r];
            end
        end
    end

    // Reference model: pending updates as a queue, architectural BTB contents as plain arrays.
    typedef struct {
        logic [EW-1:0] pc;
        logic [EW-1:0] tgt;
    } upd_t;

    upd_t          q[$];
    int            blocked = 0;
    bit            m_pend_v = 1'b0;
    logic [EW-1:0] m_pend_pc = '0;
    bit            m_pend_hit = 1'b0;
    logic [EW-1:0] m_pend_tgt = '0;
    bit            arch_v [N];
    logic [TW-1:0] arch_tag [N];
    logic [EW-1:0] arch_tgt [N];

    function automatic int idx_of(input logic [EW-1:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int tag_of(input logic [EW-1:0] pc);
        return int'((pc >> (IW + 2)) % (1 << TW));
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_cycle();
        bit full, ne, pv, drn, fr;
        int i;
        if (!reset_n) begin
            check("rst_fetch_ready", 64'(fetch_ready), 0);
            check("rst_upd_ready", 64'(upd_ready), 0);
            check("rst_pred_v", 64'(pred_v), 0);
            check("rst_r_v", 64'(btb_r_v), 0);
            check("rst_w_v", 64'(btb_w_v), 0);
            q.delete();
            blocked  = 0;
            m_pend_v = 1'b0;
            for (int k = 0; k < N; k++) arch_v[k] = 1'b0;
            return;
        end
        full = (q.size() == 2);
        ne   = (q.size() != 0);
        pv   = m_pend_v && !flush;
        check("pred_v", 64'(pred_v), 64'(pv));
        if (pv) begin
            check("pred_pc", 64'(pred_pc), 64'(m_pend_pc));
            check("pred_hit", 64'(pred_hit), 64'(m_pend_hit));
            check("pred_target", 64'(pred_target), 64'(m_pend_tgt));
        end
        drn = ne && (full || blocked >= SL - 1 || !fetch_v || flush);
        check("w_v", 64'(btb_w_v), 64'(drn));
        if (drn) begin
            check("idx_w", 64'(btb_idx_w), 64'(idx_of(q[0].pc)));
            check("target_w", 64'(btb_target_w), 64'(q[0].tgt));
        end
        fr = !drn && !flush;
        check("fetch_ready", 64'(fetch_ready), 64'(fr));
        check("r_v", 64'(btb_r_v), 64'(fetch_v && fr));
        check("idx_r", 64'(btb_idx_r), 64'(idx_of(fetch_pc)));
        check("upd_ready", 64'(upd_ready), 64'(!full));

        if (fetch_v && fr) begin
            i          = idx_of(fetch_pc);
            m_pend_v   = 1'b1;
            m_pend_pc  = fetch_pc;
            m_pend_hit = arch_v[i] && (int'(arch_tag[i]) == tag_of(fetch_pc));
            m_pend_tgt = m_pend_hit ? arch_tgt[i] : '0;
        end else begin
            m_pend_v = 1'b0;
        end
        if (drn) begin
            i           = idx_of(q[0].pc);
            arch_v[i]   = 1'b1;
            arch_tag[i] = TW'(tag_of(q[0].pc));
            arch_tgt[i] = q[0].tgt;
            void'(q.pop_front());
        end
        blocked = (ne && !drn) ? ((blocked + 1 > SL - 1) ? SL - 1 : blocked + 1) : 0;
        if (upd_v && !full) q.push_back('{pc: upd_pc, tgt: upd_target});
    endtask

    task automatic step(input bit rn, input bit fl, input bit fv, input logic [EW-1:0] fpc,
                        input bit uv, input logic [EW-1:0] upc, input logic [EW-1:0] ut);
        @(posedge clk);
        #1;
        reset_n    = rn;
        flush      = fl;
        fetch_v    = fv;
        fetch_pc   = fpc;
        upd_v      = uv;
        upd_pc     = upc;
        upd_target = ut;
        @(negedge clk);
        model_cycle();
    endtask

    function automatic logic [EW-1:0] rand_pc();
        logic [63:0] r;
        r        = {$urandom, $urandom};
        r[10:2]  = 9'($urandom_range(0, 3));
        r[18:11] = 8'($urandom_range(0, 2));
        return r[EW-1:0];
    endfunction

    initial begin
        logic [EW-1:0] rt;

        // Reset then a cold lookup
        step(0, 0, 0, '0, 0, '0, '0);
        step(0, 0, 1, 39'h1000, 1, 39'h1000, 39'h9);
        step(1, 0, 1, 39'h1000, 0, '0, '0);
        check("lit_cold_accept", 64'(btb_r_v), 1);
        step(1, 0, 0, '0, 0, '0, '0);
        check("lit_cold_pred_v", 64'(pred_v), 1);
        check("lit_cold_hit", 64'(pred_hit), 0);
        check("lit_cold_target", 64'(pred_target), 0);

        // Update with fetch idle drains next cycle; then hit, then same index different tag
        step(1, 0, 0, '0, 1, 39'h1000, 39'h2000);
        step(1, 0, 0, '0, 0, '0, '0);
        check("lit_drain_w_v", 64'(btb_w_v), 1);
        check("lit_drain_target", 64'(btb_target_w), 64'h2000);
        step(1, 0, 1, 39'h1000, 0, '0, '0);
        step(1, 0, 1, 39'h1800, 0, '0, '0);
        check("lit_hit", 64'(pred_hit), 1);
        check("lit_hit_target", 64'(pred_target), 64'h2000);
        step(1, 0, 0, '0, 0, '0, '0);
        check("lit_alias_hit", 64'(pred_hit), 0);
        check("lit_alias_target", 64'(pred_target), 0);

        // Starvation under continuous fetch
        step(1, 0, 1, 39'h40, 1, 39'h2004, 39'h3000);
        for (int k = 1; k <= 8; k++) begin
            step(1, 0, 1, 39'h40, 0, '0, '0);
            check("lit_starve_w_v", 64'(btb_w_v), 64'(k == 8));
            check("lit_starve_fetch_ready", 64'(fetch_ready), 64'(k != 8));
            check("lit_rw_exclusive", 64'(btb_r_v & btb_w_v), 0);
        end

        // Three back-to-back updates under continuous fetch
        step(1, 0, 1, 39'h40, 1, 39'h100, 39'hA00);
        check("lit_fill_ready1", 64'(upd_ready), 1);
        step(1, 0, 1, 39'h40, 1, 39'h200, 39'hB00);
        check("lit_fill_ready2", 64'(upd_ready), 1);
        step(1, 0, 1, 39'h40, 1, 39'h300, 39'hC00);
        check("lit_fill_ready3", 64'(upd_ready), 0);
        check("lit_full_drain_idx", 64'(btb_idx_w), 64'h40);
        step(1, 0, 1, 39'h40, 1, 39'h300, 39'hC00);
        check("lit_retry_ready", 64'(upd_ready), 1);
        step(1, 0, 1, 39'h40, 0, '0, '0);
        check("lit_second_drain_idx", 64'(btb_idx_w), 64'h80);
        step(1, 0, 0, '0, 0, '0, '0);
        check("lit_third_drain_idx", 64'(btb_idx_w), 64'hC0);
        step(1, 0, 1, 39'h100, 0, '0, '0);
        step(1, 0, 1, 39'h200, 0, '0, '0);
        check("lit_read_a", 64'(pred_target), 64'hA00);
        step(1, 0, 1, 39'h300, 0, '0, '0);
        check("lit_read_b", 64'(pred_target), 64'hB00);
        step(1, 0, 0, '0, 0, '0, '0);
        check("lit_read_c", 64'(pred_target), 64'hC00);

        // Flush kills the in-flight prediction but still drains the FIFO
        step(1, 0, 1, 39'h100, 1, 39'h400, 39'hD00);
        step(1, 1, 1, 39'h100, 0, '0, '0);
        check("lit_flush_pred_v", 64'(pred_v), 0);
        check("lit_flush_fetch_ready", 64'(fetch_ready), 0);
        check("lit_flush_w_v", 64'(btb_w_v), 1);

        // Reset with a full FIFO and a lookup in flight
        step(1, 0, 1, 39'h100, 1, 39'h500, 39'hE00);
        step(1, 0, 1, 39'h100, 1, 39'h600, 39'hF00);
        step(0, 0, 1, 39'h100, 1, 39'h700, 39'h1);
        check("lit_midrst_w_v", 64'(btb_w_v), 0);
        step(1, 0, 0, '0, 0, '0, '0);
        check("lit_postrst_pred_v", 64'(pred_v), 0);
        check("lit_postrst_w_v", 64'(btb_w_v), 0);
        check("lit_postrst_upd_ready", 64'(upd_ready), 1);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rt = {$urandom, $urandom};
            step($urandom_range(0, 199) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 8, rand_pc(),
                 $urandom_range(0, 3) == 0, rand_pc(), rt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
